fork_vc_inport_buffer: RTL and testbench

Parametrised next-generation input-port buffer for the fork (multicast) router. It holds per-VC flit FIFOs and attaches an outport vector to every flit. It replicates each head-of-line flit to all requested outports, which may accept in different cycles. A flit is retired, and its credit returned upstream, only after every requested outport has accepted it.

---
 rtl/fork_vc_inport_buffer.sv | 182 ++++++++++++++++++
 tb/tb_fork_vc_inport_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fork_vc_inport_buffer.sv
// Multicast router input port: per-VC flit FIFOs tagged with outport vectors,
// head flit forked to every requested outport and retired once all have accepted it.
module fork_vc_inport_buffer #(
  parameter int no_outport                 = 6,
  parameter int no_vc                      = 4,
  parameter int floorplusone_log2_no_vc    = 3,
  parameter int phit_size                  = 16,
  parameter int buf_size                   = 4,
  parameter int floorplusone_log2_buf_size = 3,
  parameter int multicast_mode             = 1
) (
  input  logic                               clk,
  input  logic                               rs,
  input  logic [phit_size-1:0]               indata,
  input  logic                               in_new,
  input  logic [floorplusone_log2_no_vc-1:0] invc_no,
  input  logic                               in_head,
  input  logic [no_outport-1:0]              in_outport_vec,
  output logic [no_vc-1:0]                   ready_vec,
  output logic [phit_size-1:0]               outdata,
  output logic [no_outport-1:0]              out_req_vec,
  output logic [floorplusone_log2_no_vc-1:0] out_vc_no,
  input  logic [no_outport-1:0]              ok_vec,
  output logic                               credit_out,
  output logic [floorplusone_log2_no_vc-1:0] credit_vc,
  output logic                               overflow_err
);

  localparam int VW = floorplusone_log2_no_vc;
  localparam int CW = floorplusone_log2_buf_size;
  localparam int VI = (no_vc > 1) ? $clog2(no_vc) : 1;
  localparam int BI = $clog2(buf_size);
  localparam logic [CW-1:0] CNT_FULL = CW'(buf_size);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BI-1:0] PTR_LAST = BI'(buf_size - 1);
  localparam logic [BI-1:0] PTR_ONE  = BI'(1);
  localparam logic [no_outport-1:0] VEC_ONE = no_outport'(1);

  typedef enum logic {IDLE, SERVE} state_t;

  logic [phit_size-1:0]  mem_data [no_vc][buf_size];
  logic [no_outport-1:0] mem_vec  [no_vc][buf_size];
  logic                  mem_head [no_vc][buf_size];
  logic [BI-1:0]         wr_ptr   [no_vc];
  logic [BI-1:0]         rd_ptr   [no_vc];
  logic [CW-1:0]         count    [no_vc];
  logic [no_outport-1:0] route    [no_vc];

  state_t                state;
  logic [no_outport-1:0] pending;
  logic [VW-1:0]         sel_vc;

  logic [VI-1:0]         wr_idx, sel_idx;
  logic                  wr_valid, wr_full, push_ok, push_sel;
  logic [no_outport-1:0] raw_vec, wr_vec, next_vec;
  logic [BI-1:0]         head_ptr, next_ptr;
  logic [CW-1:0]         count_sel;
  logic                  pop, is_tail, found;
  logic [VW-1:0]         nxt_vc;

  function automatic logic [BI-1:0] bump(input logic [BI-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Unicast mode keeps only the lowest requested outport of each vector.
  always_comb begin
    wr_idx   = invc_no[VI-1:0];
    wr_valid = in_new && (int'(invc_no) < no_vc);
    wr_full  = (count[wr_idx] == CNT_FULL);
    push_ok  = wr_valid && !wr_full;
    raw_vec  = in_head ? in_outport_vec : route[wr_idx];
    wr_vec   = (multicast_mode != 0) ? raw_vec : (raw_vec & (~raw_vec + VEC_ONE));
  end

  // A popped flit ends its packet when the VC drains or the following entry is a header;
  // a push landing in the same cycle counts as that following entry.
  always_comb begin
    sel_idx   = sel_vc[VI-1:0];
    head_ptr  = rd_ptr[sel_idx];
    next_ptr  = bump(head_ptr);
    count_sel = count[sel_idx];
    push_sel  = push_ok && (wr_idx == sel_idx);
    pop       = (state == SERVE) && (count_sel != '0) && ((pending & ~ok_vec) == '0);
    if (count_sel == CNT_ONE) begin
      is_tail  = !(push_sel && !in_head);
      next_vec = wr_vec;
    end else begin
      is_tail  = mem_head[sel_idx][next_ptr];
      next_vec = mem_vec[sel_idx][next_ptr];
    end
  end

  always_comb begin
    nxt_vc = sel_vc;
    found  = 1'b0;
    for (int i = 1; i < no_vc; i++) begin
      if (!found && (count[VI'((int'(sel_idx) + i) % no_vc)] != '0)) begin
        nxt_vc = VW'((int'(sel_idx) + i) % no_vc);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < no_vc; v++) ready_vec[v] = (count[v] != CNT_FULL);
    outdata     = mem_data[sel_idx][head_ptr];
    out_req_vec = (state == SERVE) ? pending : '0;
    out_vc_no   = sel_vc;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_idx][wr_ptr[wr_idx]] <= indata;
      mem_vec[wr_idx][wr_ptr[wr_idx]]  <= wr_vec;
      mem_head[wr_idx][wr_ptr[wr_idx]] <= in_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rs) begin
      for (int v = 0; v < no_vc; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
        route[v]  <= '0;
      end
      overflow_err <= 1'b0;
    end else begin
      if (wr_valid && wr_full) overflow_err <= 1'b1;
      if (push_ok && in_head) route[wr_idx] <= in_outport_vec;
      for (int v = 0; v < no_vc; v++) begin
        if (push_ok && (wr_idx == VI'(v))) wr_ptr[v] <= bump(wr_ptr[v]);
        if (pop && (sel_idx == VI'(v)))    rd_ptr[v] <= bump(rd_ptr[v]);
        if ((push_ok && (wr_idx == VI'(v))) && !(pop && (sel_idx == VI'(v))))
          count[v] <= count[v] + CNT_ONE;
        else if (!(push_ok && (wr_idx == VI'(v))) && (pop && (sel_idx == VI'(v))))
          count[v] <= count[v] - CNT_ONE;
      end
    end
  end

  // Within a packet the next head is reloaded without a bubble; the VC is only
  // released after its tail flit, so packets never interleave on the outports.
  always_ff @(posedge clk) begin
    if (!rs) begin
      state      <= IDLE;
      pending    <= '0;
      sel_vc     <= '0;
      credit_out <= 1'b0;
      credit_vc  <= '0;
    end else begin
      credit_out <= 1'b0;
      case (state)
        IDLE: begin
          if (count_sel != '0) begin
            pending <= mem_vec[sel_idx][head_ptr];
            state   <= SERVE;
          end else begin
            sel_vc <= nxt_vc;
          end
        end
        SERVE: begin
          if (pop) begin
            credit_out <= 1'b1;
            credit_vc  <= sel_vc;
            if (is_tail) begin
              pending <= '0;
              state   <= IDLE;
              sel_vc  <= nxt_vc;
            end else begin
              pending <= next_vec;
            end
          end else begin
            pending <= pending & ~ok_vec;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fork_vc_inport_buffer.sv
// Directed self-checking bench: fork, staggered accepts, overflow, VC ordering,
// unicast reduction and reset during a fork.
module tb_fork_vc_inport_buffer;

  logic        clk = 1'b0;
  logic        rs;
  logic [15:0] indata;
  logic        in_new;
  logic [2:0]  invc_no;
  logic        in_head;
  logic [5:0]  in_outport_vec;
  logic [5:0]  ok_vec;

  logic [3:0]  ready_vec, uni_ready_vec;
  logic [15:0] outdata, uni_outdata;
  logic [5:0]  out_req_vec, uni_out_req_vec;
  logic [2:0]  out_vc_no, uni_out_vc_no;
  logic        credit_out, uni_credit_out;
  logic [2:0]  credit_vc, uni_credit_vc;
  logic        overflow_err, uni_overflow_err;

  int errors = 0;
  int checks = 0;
  int cred_q[$];
  int exp_cred[6] = '{1, 1, 1, 3, 3, 3};
  logic [15:0] drain_data[4] = '{16'hC002, 16'hC003, 16'hC006, 16'hC007};

  always #5 clk = ~clk;

  fork_vc_inport_buffer dut (
    .clk(clk), .rs(rs), .indata(indata), .in_new(in_new), .invc_no(invc_no),
    .in_head(in_head), .in_outport_vec(in_outport_vec), .ready_vec(ready_vec),
    .outdata(outdata), .out_req_vec(out_req_vec), .out_vc_no(out_vc_no),
    .ok_vec(ok_vec), .credit_out(credit_out), .credit_vc(credit_vc),
    .overflow_err(overflow_err)
  );

  fork_vc_inport_buffer #(.multicast_mode(0)) uni (
    .clk(clk), .rs(rs), .indata(indata), .in_new(in_new), .invc_no(invc_no),
    .in_head(in_head), .in_outport_vec(in_outport_vec), .ready_vec(uni_ready_vec),
    .outdata(uni_outdata), .out_req_vec(uni_out_req_vec), .out_vc_no(uni_out_vc_no),
    .ok_vec(ok_vec), .credit_out(uni_credit_out), .credit_vc(uni_credit_vc),
    .overflow_err(uni_overflow_err)
  );

  // One clock edge with the given inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic nw, input logic [2:0] vc, input logic hd,
                               input logic [5:0] vec, input logic [15:0] dat,
                               input logic [5:0] ok);
    in_new         = nw;
    invc_no        = vc;
    in_head        = hd;
    in_outport_vec = vec;
    indata         = dat;
    ok_vec         = ok;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rs = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_ready", ready_vec, 4'b1111);
    checkOutput("rst_req", out_req_vec, 6'b0);
    checkOutput("rst_credit", credit_out, 0);
    checkOutput("rst_ovf", overflow_err, 0);
    rs = 1'b1;

    $display("[TB] single header fork");
    applyStimulus(1, 0, 1, 6'b000101, 16'hA001, 6'b000101);
    checkOutput("t1_req_write", out_req_vec, 6'b0);
    applyStimulus(0, 0, 0, 0, 0, 6'b000101);
    checkOutput("t1_req", out_req_vec, 6'b000101);
    checkOutput("t1_data", outdata, 16'hA001);
    checkOutput("t1_vcno", out_vc_no, 0);
    checkOutput("t1_nocred", credit_out, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'b000101);
    checkOutput("t1_cred", credit_out, 1);
    checkOutput("t1_credvc", credit_vc, 0);
    checkOutput("t1_req_done", out_req_vec, 6'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_cred_once", credit_out, 0);

    $display("[TB] staggered accepts");
    applyStimulus(1, 0, 1, 6'b110000, 16'hB000, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_req_full", out_req_vec, 6'b110000);
    applyStimulus(0, 0, 0, 0, 0, 6'b010000);
    checkOutput("t2_req_part", out_req_vec, 6'b100000);
    checkOutput("t2_nocred", credit_out, 0);
    applyStimulus(0, 0, 0, 0, 0, 6'b100000);
    checkOutput("t2_cred", credit_out, 1);
    checkOutput("t2_req_done", out_req_vec, 6'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_cred_once", credit_out, 0);

    $display("[TB] zero vector header");
    applyStimulus(1, 0, 1, 6'b000000, 16'hD000, 0);
    checkOutput("tz_nocred_w", credit_out, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("tz_req", out_req_vec, 6'b0);
    checkOutput("tz_nocred_l", credit_out, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("tz_cred", credit_out, 1);
    checkOutput("tz_credvc", credit_vc, 0);

    $display("[TB] fill VC2 and overflow");
    applyStimulus(1, 2, 1, 6'b000001, 16'hC000, 0);
    applyStimulus(1, 2, 0, 6'b111111, 16'hC001, 0);
    applyStimulus(1, 2, 0, 6'b111111, 16'hC002, 0);
    applyStimulus(1, 2, 0, 6'b111111, 16'hC003, 0);
    checkOutput("t3_ready_full", ready_vec, 4'b1011);
    checkOutput("t3_ovf0", overflow_err, 0);
    checkOutput("t3_req_route", out_req_vec, 6'b000001);
    applyStimulus(1, 2, 0, 6'b111111, 16'hC004, 0);
    checkOutput("t3_ready_ovf", ready_vec, 4'b1011);
    checkOutput("t3_ovf1", overflow_err, 1);
    applyStimulus(1, 2, 0, 6'b111111, 16'hC005, 6'b000001);
    checkOutput("t3_full_pp_ready", ready_vec, 4'b1111);
    checkOutput("t3_full_pp_cred", credit_out, 1);
    checkOutput("t3_full_pp_vc", credit_vc, 2);
    checkOutput("t3_full_pp_data", outdata, 16'hC001);
    applyStimulus(1, 2, 0, 6'b111111, 16'hC006, 6'b000001);
    checkOutput("t3_pp_ready", ready_vec, 4'b1111);
    checkOutput("t3_pp_cred", credit_out, 1);
    checkOutput("t3_pp_data", outdata, 16'hC002);
    applyStimulus(1, 2, 0, 6'b111111, 16'hC007, 0);
    checkOutput("t3_refill_ready", ready_vec, 4'b1011);
    checkOutput("t3_refill_nocred", credit_out, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3_drain_data%0d", i), outdata, drain_data[i]);
      applyStimulus(0, 0, 0, 0, 0, 6'b000001);
      checkOutput($sformatf("t3_drain_cred%0d", i), credit_out, 1);
    end
    checkOutput("t3_empty_ready", ready_vec, 4'b1111);
    checkOutput("t3_empty_req", out_req_vec, 6'b0);
    checkOutput("t3_ovf_sticky", overflow_err, 1);

    $display("[TB] two packets on VC1 and VC3");
    applyStimulus(1, 1, 1, 6'b000010, 16'hD100, 0);
    applyStimulus(1, 1, 0, 6'b000000, 16'hD101, 0);
    applyStimulus(1, 1, 0, 6'b000000, 16'hD102, 0);
    applyStimulus(1, 3, 1, 6'b001000, 16'hE300, 0);
    applyStimulus(1, 3, 0, 6'b000000, 16'hE301, 0);
    applyStimulus(1, 3, 0, 6'b000000, 16'hE302, 0);
    checkOutput("t4_first_vc", out_vc_no, 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 6'b111111);
      if (credit_out) cred_q.push_back(int'(credit_vc));
    end
    checkOutput("t4_ncred", cred_q.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t4_cred%0d", i),
                  (i < cred_q.size()) ? cred_q[i] : 32'hFFFF_FFFF, exp_cred[i]);

    $display("[TB] unicast reduction");
    rs = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rs = 1'b1;
    checkOutput("t5_ovf_rst", overflow_err, 0);
    applyStimulus(1, 0, 1, 6'b101100, 16'h5A5A, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_uni_req", uni_out_req_vec, 6'b000100);
    checkOutput("t5_multi_req", out_req_vec, 6'b101100);
    applyStimulus(0, 0, 0, 0, 0, 6'b001000);
    checkOutput("t5_uni_ignore", uni_out_req_vec, 6'b000100);
    checkOutput("t5_multi_part", out_req_vec, 6'b100100);

    $display("[TB] reset mid fork");
    rs = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rs = 1'b1;
    applyStimulus(1, 0, 1, 6'b110000, 16'h7777, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t6_req_before", out_req_vec, 6'b110000);
    rs = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 6'b110000);
    checkOutput("t6_req_rst", out_req_vec, 6'b0);
    checkOutput("t6_cred_rst", credit_out, 0);
    checkOutput("t6_ready_rst", ready_vec, 4'b1111);
    rs = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 6'b110000);
    checkOutput("t6_cred_after", credit_out, 0);
    checkOutput("t6_req_after", out_req_vec, 6'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
